// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants: host-tx state codes, frame bit indices, cycle helpers
package ps2_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // bitcnt values at which the parity, stop and ACK slots are handled
    localparam logic [3:0] PARITY_IDX = 4'd8;
    localparam logic [3:0] STOP_IDX   = 4'd9;
    localparam logic [3:0] ACK_IDX    = 4'd10;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer for PS/2 clock/data plus clock falling-edge detect
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2clk,
    input  logic ps2dat,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2clk};
        dat_sync_d = {dat_sync_q[0], ps2dat};
        clk_prev_d = clk_sync_q[1];
    end

    // Reset to the idle-high line level so leaving reset never fakes a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with open-drain line drives
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2dat,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       clk_drive_low,
    output logic       dat_drive_low,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_s, dat_s, fall;

    ps2_line_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .ps2clk (ps2clk),
        .ps2dat (ps2dat),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .fall   (fall)
    );

    logic [2:0]       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             nack_q, nack_d;
    logic             clk_drv_q, clk_drv_d;
    logic             dat_drv_q, dat_drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        clk_drv_d = clk_drv_q;
        dat_drv_d = dat_drv_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    shift_d   = tx_data;
                    err_d     = 1'b0;
                    nack_d    = 1'b0;
                    inh_cnt_d = '0;
                    clk_drv_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    dat_drv_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                clk_drv_d = 1'b0;
                tmo_cnt_d = '0;
                bitcnt_d  = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT, ST_WAIT_IDLE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // The timeout wins over any same-cycle clock edge or idle detection
                if (tmo_cnt_q == TMO_LAST) begin
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b0;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (state_q == ST_SHIFT) begin
                    if (fall) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q < PARITY_IDX) begin
                            dat_drv_d = ~shift_q[bitcnt_q[2:0]];
                        end else if (bitcnt_q == PARITY_IDX) begin
                            dat_drv_d = ~odd_parity(shift_q);
                        end else if (bitcnt_q == STOP_IDX) begin
                            dat_drv_d = 1'b0;
                        end else if (bitcnt_q >= ACK_IDX) begin
                            nack_d    = dat_s;
                            dat_drv_d = 1'b0;
                            state_d   = ST_WAIT_IDLE;
                        end
                    end
                end else if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = nack_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_drv_d = 1'b0;
                dat_drv_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            clk_drv_q <= clk_drv_d;
            dat_drv_q <= dat_drv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign clk_drive_low = clk_drv_q;
    assign dat_drive_low = dat_drv_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the outbound counterpart of the keyboard receiver (`ps2_communication`). The CPU bus glue hands it one command byte, e.g. 0xED (set LEDs) or 0xFF (reset). It performs the bus-inhibit and request-to-send sequence, then shifts the byte out on keyboard-generated clocks with odd parity and checks the device ACK. It drives the PS/2 lines open-drain, only ever pulling them low; the top level owns the tristate buffers.

## Interface
- `CLK_HZ`, 50_000_000: `clk` frequency.
- `INHIBIT_US`, 100: clock-low inhibit time; `INHIBIT_CYCLES = CLK_HZ/1_000_000*INHIBIT_US`.
- `TIMEOUT_US`, 15000: maximum time from clock release to ACK.
- `clk` in 1: system clock; 50 MHz domain shared with the keyboard receiver.
- `reset` in 1: synchronous, active-high.
- `ps2clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2dat` in 1: raw PS/2 data pin, asynchronous.
- `tx_data` in 8: byte to send; sampled when `tx_start` is accepted.
- `tx_start` in 1: single-cycle request; accepted only when `busy`=0.
- `clk_drive_low` out 1: 1 means pull PS/2 clock low, 0 means release it.
- `dat_drive_low` out 1: 1 means pull PS/2 data low, 0 means release it.
- `busy` out 1: transfer in progress. The top level uses it to hold the receiver in reset.
- `done` out 1: one-cycle pulse when a transfer ends, whether it succeeded or failed.
- `err` out 1: level set when a transfer ends in NACK or timeout; cleared by the next accepted `tx_start` or by `reset`.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge of `ps2clk` is detected as synchronized previous=1, current=0 and produces `fall` for one cycle.
- Frame on the wire: start bit 0, `tx_data[0..7]` LSB first, parity `~^tx_data` (odd), stop bit 1, then the device ACK (0).
- States:
  - IDLE: lines released. On `tx_start`: latch the byte into the shift register, clear `err`, go to INHIBIT.
  - INHIBIT: `clk_drive_low`=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: `dat_drive_low`=1 with the clock still held low for 1 cycle, then `clk_drive_low`=0. Clear the timeout counter, clear `bitcnt`, go to SHIFT.
  - SHIFT: on each `fall`, increment `bitcnt`:
    - `bitcnt` 0–7: drive data bit n (`dat_drive_low = ~bit`).
    - `bitcnt` 8: drive parity.
    - `bitcnt` 9: release data (stop).
    - `bitcnt` 10: sample synchronized `ps2dat`; 0 is ACK, 1 is NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: lines released. Wait until synchronized clock and data are both 1, then pulse `done` (with `err`=1 if NACK) and go to IDLE.
- Timeout: a counter runs during SHIFT and WAIT_IDLE. When it reaches `TIMEOUT_US` worth of cycles: release both lines, set `err`, pulse `done`, go to IDLE.
- `tx_start` while `busy`=1 is ignored; `tx_data` is not re-sampled.
- `reset` at any time: IDLE, all outputs 0, shift register and counters cleared.

## Timing
- Reset values: `clk_drive_low`=0, `dat_drive_low`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered.
- `tx_start` accepted at edge k:
  - `busy`=1 and `clk_drive_low`=1 from cycle k+1.
  - `dat_drive_low`=1 from cycle k+1+INHIBIT_CYCLES.
  - Clock released one cycle later.
- A data change follows a physical clock falling edge by 3–4 `clk` cycles (synchronizer plus register). This is well inside the device's half period of 30 µs or more.
- `done` and `busy`=0 are asserted in the same cycle. A new `tx_start` may be accepted in the next cycle.
- Counter widths are `$clog2` of the cycle counts; at 50 MHz the timeout counter is 20 bits and the inhibit counter 13 bits.

## Structure
- `ps2_pkg`: state encodings, the cycle-count constant functions, and the frame bit indices (PARITY_IDX=8, STOP_IDX=9, ACK_IDX=10).
- Sub-module `ps2_line_sync`: 2-flop synchronizer plus falling-edge detector for clock and data. It is shared with the receiver.
- The top level maps the outputs to pins as `ps2_clk = clk_drive_low ? 0 : z` and `ps2_data = dat_drive_low ? 0 : z`.

## Test plan
- **0xED with device model ACK:** data sequence on successive falls is 1,0,1,1,0,1,1,1, parity 1, then released. ACK sampled 0, `done` pulses, `err`=0.
- **0xF4:** parity bit 0. Inhibit phase measured at exactly 5000 cycles of `clk_drive_low`=1 (parameters 50 MHz / 100 µs).
- **0x00 with device returning NACK (data 1 at 11th fall):** parity 1 on the wire; `done` pulses and `err`=1 stays set. The next `tx_start` clears it.
- **Device model never clocks:** timeout fires after 750000 cycles, both drives go to 0, `err`=1, `busy`=0.
- **`tx_start` with 0x55 issued at the 4th fall of a 0xED transfer:** ignored; the wire still carries 0xED.
- **`reset` asserted after the 5th fall:** next cycle both drives are 0 and `busy`=0. A following 0xFF transfer completes with ACK.
